ob_cmd_deser: RTL and testbench
===============================

Name: ob_cmd_deser

Overview:
- Byte-stream command deserializer directly upstream of the order-book top level.
- Accepts a byte-wide valid/ready stream from the host link, frames variable-length commands by opcode, and packs each into one wide command word.
- Presents each word as a single-cycle registered push (cmd_vld_r/cmd_r) into the order book's ingress queue, honouring its registered full flag (cmd_full_r).
- Also flags illegal opcodes and keeps command and error counters.

Parameters:
- CMD_BYTES, 13, bytes per packed command word. Layout is opcode(1), uid(4), qty(4), price(4); cmd_r width = 8*CMD_BYTES.
- CNT_W, 16, width of the emitted-command counter.
- ERR_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_vld  in  1  input byte valid.
- in_dat  in  8  input byte.
- in_rdy  out  1  input byte ready; a byte transfers when in_vld & in_rdy.
- cmd_full_r  in  1  order-book ingress queue full (registered, one-cycle lag).
- cmd_vld_r  out  1  registered one-cycle push strobe to the order book.
- cmd_r  out  8*CMD_BYTES  packed command. Opcode in the MS byte, then fields big-endian.
- err_illegal_r  out  1  registered one-cycle pulse on illegal opcode.
- cmd_cnt_r  out  CNT_W  commands emitted, wrapping.
- err_cnt_r  out  ERR_W  illegal opcodes seen, saturating at all-ones.

Behaviour:
- Reset (rst=0, async): state=IDLE; byte counter=0; assembly buffer=0. All outputs are 0 except in_rdy, which is 1 once state=IDLE after reset release.
- Opcodes and total frame lengths:
  - 0x00 NOP: 1 byte, consumed and discarded, no emit.
  - 0x01 BUY: 13 bytes.
  - 0x02 SELL: 13 bytes.
  - 0x03 CANCEL: 5 bytes (opcode+uid). qty and price bytes are zero-filled in cmd_r.
  - Any other value is illegal.
- State IDLE, in_rdy=1, on a transferred byte:
  - NOP: stay IDLE.
  - Illegal: err_illegal_r=1 next cycle; err_cnt_r increments unless saturated; stay IDLE; byte dropped.
  - BUY/SELL/CANCEL: latch the opcode into the MS byte, clear the remaining buffer bytes, load remaining=len-1, go to COLLECT.
- State COLLECT, in_rdy=1:
  - Each transferred byte fills the next byte position downward from the MS byte, and remaining decrements.
  - When the byte with remaining==1 transfers, go to HOLD.
  - in_vld=0 cycles are bubbles: no state change, no timeout.
- State HOLD, in_rdy=0:
  - If cmd_full_r=0 this cycle: at the next edge set cmd_vld_r=1, load cmd_r from the buffer, increment cmd_cnt_r (wraps), go to IDLE.
  - If cmd_full_r=1: remain in HOLD and hold the buffer.
- cmd_vld_r is high for exactly one cycle per command. cmd_r keeps its last value when cmd_vld_r=0.
- Latency: last byte transferred at edge E → HOLD during cycle E..E+1 → cmd_vld_r high in cycle E+1..E+2 when not full. in_rdy returns to 1 in the same cycle cmd_vld_r is high.
- Minimum spacing between pushes is 6 cycles (shortest frame of 5 bytes plus 1 HOLD cycle). This exceeds the one-cycle lag of cmd_full_r, so the ingress queue can never be overrun.
- cmd_full_r is ignored outside HOLD.
- Reset asserted mid-frame discards the partial frame. No emit occurs and the counters clear.
- in_dat is sampled only on transfer. An X on in_dat when in_vld=0 must not propagate to state.

Test Plan:
- Reset then BUY frame 01 00000007 0000000A 00000064, back-to-back bytes → cmd_vld_r one cycle, 2 cycles after the 13th byte; cmd_r=0x01_00000007_0000000A_00000064; cmd_cnt_r=1.
- CANCEL frame 03 DEADBEEF with in_vld bubbles between bytes → cmd_r=0x03_DEADBEEF_00000000_00000000; cmd_vld_r single pulse.
- SELL frame completes while cmd_full_r=1 for 5 cycles → in_rdy=0 and no push while full; push in the cycle after cmd_full_r falls; cmd_r is intact.
- Byte stream 00, 7F, 03 11223344 → NOP silent; err_illegal_r pulses once, err_cnt_r=1; CANCEL then emitted with uid 0x11223344.
- 300 illegal bytes → err_cnt_r saturates at 0xFF. 65537 NOP-separated CANCELs → cmd_cnt_r wraps to 1.
- rst asserted after byte 6 of a BUY, then a fresh CANCEL → no emit of the partial frame; the CANCEL is emitted correctly; cmd_cnt_r=1.

Source files
------------

// File: rtl/ob_cmd_deser.sv
// ob_cmd_deser: frames opcode-delimited byte commands from the host link and
// pushes each one as a single packed word into the order-book ingress queue.
// Illegal opcodes are counted and flagged; NOPs are consumed silently.
module ob_cmd_deser #(
    parameter int CMD_BYTES = 13,
    parameter int CNT_W     = 16,
    parameter int ERR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [7:0]             in_dat,
    output logic                   in_rdy,
    input  logic                   cmd_full_r,
    output logic                   cmd_vld_r,
    output logic [8*CMD_BYTES-1:0] cmd_r,
    output logic                   err_illegal_r,
    output logic [CNT_W-1:0]       cmd_cnt_r,
    output logic [ERR_W-1:0]       err_cnt_r
);

    localparam int BUF_W = 8 * CMD_BYTES;
    localparam int IDX_W = $clog2(CMD_BYTES);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BUY    = 8'h01;
    localparam logic [7:0] OP_SELL   = 8'h02;
    localparam logic [7:0] OP_CANCEL = 8'h03;

    // Bytes still to collect after the opcode, per frame type.
    localparam logic [IDX_W-1:0] REM_CANCEL = IDX_W'(4);
    localparam logic [IDX_W-1:0] REM_TRADE  = IDX_W'(CMD_BYTES - 1);
    // Byte slot just below the opcode in the assembly buffer.
    localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(CMD_BYTES - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [BUF_W-1:0]   r_buf;
    logic [IDX_W-1:0]   r_rem;
    logic [IDX_W-1:0]   r_idx;

    logic               w_xfer;
    logic               w_is_frame;
    logic               w_is_nop;
    logic               w_illegal;
    logic               w_start;
    logic               w_push;
    logic [IDX_W-1:0]   w_start_rem;

    // HOLD is the only state that refuses bytes; the assembled word waits there.
    assign in_rdy = (r_state != S_HOLD);
    assign w_xfer = in_vld && in_rdy;

    // Opcode decode; only acted on when gated by a transfer so an undriven
    // in_dat while in_vld=0 never reaches state.
    assign w_is_nop    = (in_dat == OP_NOP);
    assign w_is_frame  = (in_dat == OP_BUY) || (in_dat == OP_SELL) || (in_dat == OP_CANCEL);
    assign w_start_rem = (in_dat == OP_CANCEL) ? REM_CANCEL : REM_TRADE;

    assign w_start   = w_xfer && (r_state == S_IDLE) && w_is_frame;
    assign w_illegal = w_xfer && (r_state == S_IDLE) && !w_is_frame && !w_is_nop;
    assign w_push    = (r_state == S_HOLD) && !cmd_full_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: frame start, last byte collected, and downstream space.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_xfer && (r_rem == IDX_W'(1))) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!cmd_full_r) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Assembly buffer: opcode lands in the MS byte with the rest cleared, so a
    // short CANCEL leaves qty/price zero; later bytes fill downward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_rem <= '0;
            r_idx <= '0;
        end else if (w_start) begin
            r_buf <= {in_dat, {(BUF_W-8){1'b0}}};
            r_rem <= w_start_rem;
            r_idx <= IDX_FIRST;
        end else if ((r_state == S_COLLECT) && w_xfer) begin
            r_buf[int'(r_idx)*8 +: 8] <= in_dat;
            r_rem <= r_rem - IDX_W'(1);
            r_idx <= r_idx - IDX_W'(1);
        end
    end

    // Push strobe, command word and wrapping command counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_vld_r <= 1'b0;
            cmd_r     <= '0;
            cmd_cnt_r <= '0;
        end else begin
            cmd_vld_r <= w_push;
            if (w_push) begin
                cmd_r     <= r_buf;
                cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
            end
        end
    end

    // Illegal-opcode pulse and saturating error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_illegal_r <= 1'b0;
            err_cnt_r     <= '0;
        end else begin
            err_illegal_r <= w_illegal;
            if (w_illegal && (err_cnt_r != {ERR_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ob_cmd_deser.sv
// Testbench for ob_cmd_deser: directed frames, expected pushes and error
// pulses queued at stimulus time, popped and compared by a negedge monitor.
// The command counter is narrowed to 4 bits so wrap-around is reachable quickly.
module tb_ob_cmd_deser;

    localparam int CMD_BYTES = 13;
    localparam int CNT_W     = 4;
    localparam int ERR_W     = 8;
    localparam int CW        = 8 * CMD_BYTES;

    localparam logic [CW-1:0] W_BUY   = 104'h01_00000007_0000000A_00000064;
    localparam logic [CW-1:0] W_CAN1  = 104'h03_DEADBEEF_00000000_00000000;
    localparam logic [CW-1:0] W_SELL  = 104'h02_00000010_00000020_00000030;
    localparam logic [CW-1:0] W_CAN2  = 104'h03_11223344_00000000_00000000;
    localparam logic [CW-1:0] W_CAN3  = 104'h03_CAFEF00D_00000000_00000000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_vld = 1'b0;
    logic [7:0]       in_dat = 8'hxx;
    logic             in_rdy;
    logic             cmd_full_r = 1'b0;
    logic             cmd_vld_r;
    logic [CW-1:0]    cmd_r;
    logic             err_illegal_r;
    logic [CNT_W-1:0] cmd_cnt_r;
    logic [ERR_W-1:0] err_cnt_r;

    ob_cmd_deser #(.CMD_BYTES(CMD_BYTES), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_dat        (in_dat),
        .in_rdy        (in_rdy),
        .cmd_full_r    (cmd_full_r),
        .cmd_vld_r     (cmd_vld_r),
        .cmd_r         (cmd_r),
        .err_illegal_r (err_illegal_r),
        .cmd_cnt_r     (cmd_cnt_r),
        .err_cnt_r     (err_cnt_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0]    cmd;
        logic [CNT_W-1:0] cnt;
        int               at;
    } push_t;

    typedef struct {
        logic [ERR_W-1:0] cnt;
        int               at;
    } err_t;

    push_t push_q[$];
    err_t  err_q[$];
    push_t pe;
    err_t  ee;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [ERR_W-1:0] exp_err = '0;
    int last_edge = 0;
    logic prev_vld = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waitc;
        waitc = 0;
        in_vld = 1'b1;
        in_dat = b;
        while (!in_rdy) begin
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 200) begin
                errors++;
                $display("FAIL in_rdy_timeout: got 0 expected 1 within 200 cycles");
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk);
        #1;
        last_edge = cyc;
        in_vld = 1'b0;
        in_dat = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [CW-1:0] w, input int n, input int bub);
        for (int i = 0; i < n; i++) begin
            send_byte(w[CW-1-8*i -: 8]);
            if (i < n - 1) idle(bub);
        end
    endtask

    task automatic expect_push(input logic [CW-1:0] w, input int at);
        exp_cnt = exp_cnt + CNT_W'(1);
        push_q.push_back('{cmd: w, cnt: exp_cnt, at: at});
    endtask

    task automatic send_illegal(input logic [7:0] b);
        send_byte(b);
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        err_q.push_back('{cnt: exp_err, at: last_edge});
    endtask

    // Monitor: every push and every error pulse must match the head of its queue.
    always @(negedge clk) begin
        if (cmd_vld_r) begin
            if (prev_vld) begin
                checks++;
                errors++;
                $display("FAIL push_width: got cmd_vld_r high 2 cycles expected 1 (cycle %0d)", cyc);
            end
            if (push_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got cmd %0h expected no push (cycle %0d)", cmd_r, cyc);
            end else begin
                pe = push_q.pop_front();
                check("cmd_r", cmd_r, pe.cmd);
                check("cmd_cnt_r", CW'(cmd_cnt_r), CW'(pe.cnt));
                check("push_cycle", CW'(cyc), CW'(pe.at));
            end
        end
        if (err_illegal_r) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got err pulse expected none (cycle %0d)", cyc);
            end else begin
                ee = err_q.pop_front();
                check("err_cnt_r", CW'(err_cnt_r), CW'(ee.cnt));
                check("err_cycle", CW'(cyc), CW'(ee.at));
            end
        end
        prev_vld <= cmd_vld_r;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] w;

        // Reset values while rst is held low.
        #2;
        check("rst_cmd_vld", CW'(cmd_vld_r), '0);
        check("rst_cmd_r", cmd_r, '0);
        check("rst_err_pulse", CW'(err_illegal_r), '0);
        check("rst_cmd_cnt", CW'(cmd_cnt_r), '0);
        check("rst_err_cnt", CW'(err_cnt_r), '0);
        check("rst_in_rdy", CW'(in_rdy), CW'(1));
        idle(2);
        rst = 1'b1;
        idle(1);

        // BUY, back-to-back bytes.
        send_frame(W_BUY, 13, 0);
        expect_push(W_BUY, last_edge + 1);
        idle(3);
        check("buy_cnt", CW'(cmd_cnt_r), CW'(1));
        check("buy_in_rdy", CW'(in_rdy), CW'(1));

        // CANCEL with two bubble cycles between bytes.
        send_frame(W_CAN1, 5, 2);
        expect_push(W_CAN1, last_edge + 1);
        idle(3);

        // SELL completes while the ingress queue reports full.
        cmd_full_r = 1'b1;
        send_frame(W_SELL, 13, 0);
        for (int i = 0; i < 5; i++) begin
            check("full_in_rdy", CW'(in_rdy), '0);
            check("full_no_push", CW'(cmd_vld_r), '0);
            idle(1);
        end
        cmd_full_r = 1'b0;
        expect_push(W_SELL, cyc + 1);
        idle(1);
        check("release_push", CW'(cmd_vld_r), CW'(1));
        check("release_in_rdy", CW'(in_rdy), CW'(1));
        idle(2);

        // NOP, illegal 0x7F, then CANCEL.
        send_byte(8'h00);
        send_illegal(8'h7F);
        send_frame(W_CAN2, 5, 0);
        expect_push(W_CAN2, last_edge + 1);
        idle(3);
        check("err_cnt_one", CW'(err_cnt_r), CW'(1));

        // 300 more illegal bytes: counter saturates.
        for (int i = 0; i < 300; i++) begin
            send_illegal((i % 2 == 0) ? 8'hFF : 8'h80);
        end
        idle(3);
        check("err_cnt_sat", CW'(err_cnt_r), CW'(8'hFF));
        check("cmd_cnt_4", CW'(cmd_cnt_r), CW'(4));

        // Reset after byte 6 of a BUY discards the partial frame.
        for (int i = 0; i < 6; i++) send_byte(W_BUY[CW-1-8*i -: 8]);
        rst = 1'b0;
        exp_cnt = '0;
        exp_err = '0;
        #1;
        check("midrst_in_rdy", CW'(in_rdy), CW'(1));
        check("midrst_cmd_cnt", CW'(cmd_cnt_r), '0);
        check("midrst_err_cnt", CW'(err_cnt_r), '0);
        idle(2);
        rst = 1'b1;
        idle(1);
        send_frame(W_CAN3, 5, 0);
        expect_push(W_CAN3, last_edge + 1);
        idle(3);
        check("midrst_cancel_cnt", CW'(cmd_cnt_r), CW'(1));

        // 16 NOP-separated CANCELs wrap the 4-bit counter back to 1.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h00);
            w = {8'h03, 32'h1000_0000 + 32'(i), 64'd0};
            send_frame(w, 5, 0);
            expect_push(w, last_edge + 1);
        end
        idle(4);
        check("wrap_cnt", CW'(cmd_cnt_r), CW'(1));

        idle(5);
        check("push_q_empty", CW'(push_q.size()), '0);
        check("err_q_empty", CW'(err_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
